// File: rtl/seq_detect_multi_pkg.sv
// seq_detect_pkg: shared defaults, lane config record and masked pattern compare
package seq_detect_pkg;
  localparam int DEF_NUM_PAT = 2;
  localparam int DEF_MAX_LEN = 8;
  localparam int DEF_CNT_W = 8;
  localparam logic [15:0] DEF_PAT0 = 16'b10001;
  localparam logic [15:0] DEF_PAT1 = 16'b10101;
  localparam int DEF_LEN = 5;
  // Fields sized for the largest legal MAX_LEN; lanes use only the low bits
  typedef struct packed {
    logic [15:0] pat;
    logic [4:0]  len;
    logic        en;
  } lane_cfg_t;
  function automatic logic masked_match(input logic [15:0] hist, input logic [15:0] pat, input logic [4:0] len);
    return ((hist ^ pat) & ((16'd1 << len) - 16'd1)) == 16'd0;
  endfunction
endpackage

// File: rtl/seq_detect_multi_lane.sv
// seq_match_lane: one pattern lane with config, fill tracking, compare, hit flop and saturating counter
module seq_match_lane import seq_detect_pkg::*; #(
  parameter int          MAX_LEN = DEF_MAX_LEN,
  parameter int          CNT_W   = DEF_CNT_W,
  parameter int          LEN_W   = $clog2(MAX_LEN + 1),
  parameter logic [15:0] RST_PAT = '0,
  parameter int          RST_LEN = MAX_LEN,
  parameter bit          RST_EN  = 1'b0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [MAX_LEN-1:0] hist,
  input  logic               valid,
  input  logic               overlap,
  input  logic               cfg_we,
  input  logic [MAX_LEN-1:0] cfg_pat,
  input  logic [LEN_W-1:0]   cfg_len,
  input  logic               cfg_en,
  input  logic               cnt_clr,
  output logic               hit,
  output logic [CNT_W-1:0]   cnt
);
  lane_cfg_t        r_cfg;
  logic [4:0]       r_fill;
  logic             r_hit;
  logic [CNT_W-1:0] r_cnt;
  logic [4:0]       w_fill_inc;
  logic             w_match;
  // hist already contains this cycle's bit, so the compare sees the post-shift history
  assign w_fill_inc = (r_fill < r_cfg.len) ? r_fill + 5'd1 : r_fill;
  assign w_match    = r_cfg.en && (w_fill_inc >= r_cfg.len) && masked_match(16'(hist), r_cfg.pat, r_cfg.len);
  always_ff @(posedge clk)
    if (rst) begin
      r_cfg  <= '{pat: RST_PAT, len: 5'(RST_LEN), en: RST_EN};
      r_fill <= '0;
      r_hit  <= 1'b0;
      r_cnt  <= '0;
    end else if (cfg_we) begin
      r_cfg  <= '{pat: 16'(cfg_pat), len: 5'(cfg_len), en: cfg_en};
      r_fill <= '0;
      r_hit  <= 1'b0;
      r_cnt  <= '0;
    end else begin
      r_hit  <= valid && w_match;
      r_fill <= !valid ? r_fill : (w_match && !overlap) ? 5'd0 : w_fill_inc;
      r_cnt  <= cnt_clr ? '0 : (valid && w_match && r_cnt != '1) ? r_cnt + 1'b1 : r_cnt;
    end
  assign hit = r_hit;
  assign cnt = r_cnt;
endmodule

// File: rtl/seq_detect_multi.sv
// seq_detect_multi: programmable multi-pattern serial detector with per-lane hits,
// priority hit ID and saturating hit counters
module seq_detect_multi import seq_detect_pkg::*; #(
  parameter int NUM_PAT = DEF_NUM_PAT,
  parameter int MAX_LEN = DEF_MAX_LEN,
  parameter int CNT_W   = DEF_CNT_W,
  parameter int ID_W    = (NUM_PAT > 1) ? $clog2(NUM_PAT) : 1,
  parameter int LEN_W   = $clog2(MAX_LEN + 1)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     x,
  input  logic                     x_valid,
  input  logic                     overlap,
  input  logic                     cfg_we,
  input  logic [ID_W-1:0]          cfg_idx,
  input  logic [MAX_LEN-1:0]       cfg_pat,
  input  logic [LEN_W-1:0]         cfg_len,
  input  logic                     cfg_en,
  output logic                     cfg_err,
  input  logic                     cnt_clr,
  output logic [NUM_PAT-1:0]       hit_vec,
  output logic                     hit_any,
  output logic [ID_W-1:0]          hit_id,
  output logic [NUM_PAT*CNT_W-1:0] hit_cnt
);
  localparam int RST_LEN = (DEF_LEN > MAX_LEN) ? MAX_LEN : DEF_LEN;
  logic [MAX_LEN-1:0] r_hist;
  logic               r_cfg_err;
  logic [MAX_LEN-1:0] w_hist_nxt;
  logic               w_cfg_ok;
  assign w_hist_nxt = {r_hist[MAX_LEN-2:0], x};
  assign w_cfg_ok   = (cfg_len != '0) && (32'(cfg_len) <= MAX_LEN) && (32'(cfg_idx) < NUM_PAT);
  always_ff @(posedge clk)
    if (rst) begin
      r_hist    <= '0;
      r_cfg_err <= 1'b0;
    end else begin
      r_hist    <= x_valid ? w_hist_nxt : r_hist;
      r_cfg_err <= cfg_we && !w_cfg_ok;
    end
  assign cfg_err = r_cfg_err;
  for (genvar i = 0; i < NUM_PAT; i++) begin : g_lane
    seq_match_lane #(
      .MAX_LEN (MAX_LEN),
      .CNT_W   (CNT_W),
      .LEN_W   (LEN_W),
      .RST_PAT ((i == 0) ? DEF_PAT0 : (i == 1) ? DEF_PAT1 : 16'd0),
      .RST_LEN ((i < 2) ? RST_LEN : MAX_LEN),
      .RST_EN  (i < 2)
    ) u_lane (
      .clk     (clk),
      .rst     (rst),
      .hist    (w_hist_nxt),
      .valid   (x_valid),
      .overlap (overlap),
      .cfg_we  (cfg_we && w_cfg_ok && (32'(cfg_idx) == i)),
      .cfg_pat (cfg_pat),
      .cfg_len (cfg_len),
      .cfg_en  (cfg_en),
      .cnt_clr (cnt_clr),
      .hit     (hit_vec[i]),
      .cnt     (hit_cnt[i*CNT_W +: CNT_W])
    );
  end
  // Encoder works on the registered hit_vec, so id and any stay aligned with it
  assign hit_any = |hit_vec;
  always_comb begin
    hit_id = '0;
    for (int k = NUM_PAT - 1; k >= 0; k--) hit_id = hit_vec[k] ? ID_W'(k) : hit_id;
  end
endmodule

// File: tb/tb_seq_detect_multi.sv
// tb_seq_detect_multi: table vectors, directed corner sequences and random stimulus
// checked against a bit-queue reference model
module tb_seq_detect_multi;
  localparam int NP = 3, ML = 8, CW = 2, IW = 2, LW = 4;
  localparam int CMAX = (1 << CW) - 1;
  logic clk = 0, rst = 1, x = 0, x_valid = 0, overlap = 1, cfg_we = 0, cfg_en = 0, cnt_clr = 0;
  logic [IW-1:0] cfg_idx = '0;
  logic [ML-1:0] cfg_pat = '0;
  logic [LW-1:0] cfg_len = '0;
  logic cfg_err, hit_any;
  logic [NP-1:0] hit_vec;
  logic [IW-1:0] hit_id;
  logic [NP*CW-1:0] hit_cnt;
  int n_cmp = 0, n_err = 0;

  seq_detect_multi #(.NUM_PAT(NP), .MAX_LEN(ML), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .x(x), .x_valid(x_valid), .overlap(overlap),
    .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_pat(cfg_pat), .cfg_len(cfg_len), .cfg_en(cfg_en),
    .cfg_err(cfg_err), .cnt_clr(cnt_clr), .hit_vec(hit_vec), .hit_any(hit_any),
    .hit_id(hit_id), .hit_cnt(hit_cnt));

  always #5 clk = ~clk;

  // Reference: received bits as a queue, each lane counts bits seen since its last restart
  bit q[$];
  int m_pat[NP], m_len[NP], m_fill[NP], m_cnt[NP];
  bit m_en[NP], m_hit[NP], m_err;

  function automatic void m_reset();
    q.delete();
    for (int k = 0; k < 16; k++) q.push_back(1'b0);
    for (int k = 0; k < NP; k++) begin
      m_pat[k] = (k == 0) ? 'b10001 : (k == 1) ? 'b10101 : 0;
      m_len[k] = (k < 2) ? 5 : ML;
      m_en[k] = (k < 2);
      m_fill[k] = 0; m_cnt[k] = 0; m_hit[k] = 0;
    end
    m_err = 0;
  endfunction

  function automatic int tail(int n);
    int v = 0;
    for (int k = n; k >= 1; k--) v = (v << 1) | int'(q[q.size() - k]);
    return v;
  endfunction

  function automatic void m_step(bit r, bit xb, bit v, bit ov, bit we, int idx, int p, int l, bit e, bit clr);
    bit ok, mt;
    int f;
    if (r) begin m_reset(); return; end
    ok = we && l >= 1 && l <= ML && idx < NP;
    m_err = we && !ok;
    if (v) begin q.push_back(xb); void'(q.pop_front()); end
    for (int k = 0; k < NP; k++) begin
      m_hit[k] = 0;
      if (ok && idx == k) begin
        m_pat[k] = p; m_len[k] = l; m_en[k] = e; m_fill[k] = 0; m_cnt[k] = 0;
      end else begin
        if (v) begin
          f = (m_fill[k] + 1 > m_len[k]) ? m_len[k] : m_fill[k] + 1;
          mt = m_en[k] && f >= m_len[k] && ((m_pat[k] & ((1 << m_len[k]) - 1)) == tail(m_len[k]));
          m_hit[k] = mt;
          m_fill[k] = (mt && !ov) ? 0 : f;
          if (mt && m_cnt[k] < CMAX) m_cnt[k]++;
        end
        if (clr) m_cnt[k] = 0;
      end
    end
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare_all();
    logic [NP-1:0] ev;
    logic [NP*CW-1:0] ec;
    int id;
    id = 0;
    for (int k = NP - 1; k >= 0; k--) begin
      ev[k] = m_hit[k];
      ec[k*CW +: CW] = CW'(m_cnt[k]);
      if (m_hit[k]) id = k;
    end
    check("model_hit_vec", 32'(hit_vec), 32'(ev));
    check("model_hit_any", 32'(hit_any), 32'(|ev));
    check("model_hit_id", 32'(hit_id), 32'(id));
    check("model_hit_cnt", 32'(hit_cnt), 32'(ec));
    check("model_cfg_err", 32'(cfg_err), 32'(m_err));
  endtask

  task automatic step(input bit r, input bit xb, input bit v, input bit ov, input bit we,
                      input logic [1:0] idx, input logic [7:0] p, input logic [3:0] l, input bit e, input bit clr);
    rst = r; x = xb; x_valid = v; overlap = ov; cfg_we = we;
    cfg_idx = idx; cfg_pat = p; cfg_len = l; cfg_en = e; cnt_clr = clr;
    @(posedge clk);
    m_step(r, xb, v, ov, we, int'(idx), int'(p), int'(l), e, clr);
    #1;
    compare_all();
  endtask

  task automatic bit_in(input bit xb, input bit v, input bit ov);
    step(0, xb, v, ov, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic wr(input logic [1:0] idx, input logic [7:0] p, input logic [3:0] l, input bit e);
    step(0, 0, 0, 1, 1, idx, p, l, e, 0);
  endtask

  task automatic do_rst();
    step(1, 0, 0, 1, 0, 0, 0, 0, 0, 0);
  endtask

  typedef struct {
    bit r; bit x; bit v; bit ov;
    logic [NP-1:0] hit;
  } vec_t;
  vec_t tbl [22];

  initial begin
    int hits;
    tbl = '{
      '{1,0,0,1,3'b000}, '{0,1,1,1,3'b000}, '{0,0,1,1,3'b000}, '{0,0,1,1,3'b000},
      '{0,0,1,1,3'b000}, '{0,1,1,1,3'b001},
      '{1,0,0,1,3'b000}, '{0,1,1,1,3'b000}, '{0,0,1,1,3'b000}, '{0,1,1,1,3'b000},
      '{0,0,1,1,3'b000}, '{0,1,1,1,3'b010}, '{0,0,1,1,3'b000}, '{0,1,1,1,3'b010},
      '{1,0,0,0,3'b000}, '{0,1,1,0,3'b000}, '{0,0,1,0,3'b000}, '{0,1,1,0,3'b000},
      '{0,0,1,0,3'b000}, '{0,1,1,0,3'b010}, '{0,0,1,0,3'b000}, '{0,1,1,0,3'b000}
    };
    do_rst();
    check("reset_hit_vec", 32'(hit_vec), 0);
    check("reset_hit_cnt", 32'(hit_cnt), 0);
    check("reset_cfg_err", 32'(cfg_err), 0);
    foreach (tbl[i]) begin
      step(tbl[i].r, tbl[i].x, tbl[i].v, tbl[i].ov, 0, 0, 0, 0, 0, 0);
      check($sformatf("tbl%0d_hit_vec", i), 32'(hit_vec), 32'(tbl[i].hit));
    end
    check("tbl_cnt_after_ov0", 32'(hit_cnt), 32'(6'b00_01_00));

    // 111 with idle cycles between valid bits: two hits, none on idle cycles
    do_rst();
    wr(0, 8'b111, 3, 1);
    hits = 0;
    for (int k = 0; k < 7; k++) begin
      bit_in(1, (k % 2) == 0, 1);
      if ((k % 2) == 1) check("idle_no_hit", 32'(hit_vec[0]), 0);
      hits += int'(hit_vec[0]);
    end
    check("gap_hits", 32'(hits), 2);

    // both lanes match on the same bit
    do_rst();
    wr(0, 8'b101, 3, 1);
    wr(1, 8'b101, 3, 1);
    bit_in(1, 1, 1); bit_in(0, 1, 1); bit_in(1, 1, 1);
    check("dual_hit_vec", 32'(hit_vec), 32'(3'b011));
    check("dual_hit_id", 32'(hit_id), 0);
    check("dual_hit_cnt", 32'(hit_cnt), 32'(6'b00_01_01));

    // saturation, then clear beats a same-cycle match
    do_rst();
    wr(0, 8'b11, 2, 1);
    for (int k = 0; k < 6; k++) bit_in(1, 1, 1);
    check("sat_cnt0", 32'(hit_cnt[CW-1:0]), 3);
    step(0, 1, 1, 1, 0, 0, 0, 0, 0, 1);
    check("clr_hit", 32'(hit_vec[0]), 1);
    check("clr_cnt0", 32'(hit_cnt[CW-1:0]), 0);

    // rejected writes leave config alone
    do_rst();
    wr(0, 8'b11, 0, 1);
    check("err_len0", 32'(cfg_err), 1);
    wr(2'd3, 8'b11, 3, 1);
    check("err_idx", 32'(cfg_err), 1);
    wr(0, 8'b11, 4'd9, 1);
    check("err_len_big", 32'(cfg_err), 1);
    bit_in(0, 0, 1);
    check("err_pulse_end", 32'(cfg_err), 0);
    bit_in(1, 1, 1); bit_in(0, 1, 1); bit_in(0, 1, 1); bit_in(0, 1, 1); bit_in(1, 1, 1);
    check("err_cfg_kept", 32'(hit_vec), 32'(3'b001));

    // reset discards a partial match
    bit_in(1, 1, 1); bit_in(0, 1, 1); bit_in(0, 1, 1);
    do_rst();
    check("rst_mid_cnt", 32'(hit_cnt), 0);
    bit_in(0, 1, 1); bit_in(1, 1, 1);
    check("rst_mid_no_hit", 32'(hit_vec), 0);

    for (int n = 0; n < 3000; n++) begin
      bit r, we;
      logic [3:0] l;
      r = ($urandom_range(0, 199) == 0);
      we = ($urandom_range(0, 24) == 0);
      l = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 9)) : 4'($urandom_range(1, 4));
      step(r, 1'($urandom), $urandom_range(0, 3) != 0, 1'($urandom), we, 2'($urandom_range(0, 3)),
           8'($urandom), l, $urandom_range(0, 3) != 0, $urandom_range(0, 49) == 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
